hw_result_streamer: RTL and testbench
=====================================

Name: hw_result_streamer

Overview:
- Downstream stage of the fixed-point add/multiply accelerator.
- Waits for the accelerator's `done` to rise, then latches the burst length.
- Serialises the accelerator's flattened sum/product result buses into a valid/ready stream, one element per beat, for the host DMA/FIFO.
- Owns frame sequencing and back-pressure so the accelerator core needs no output handshake.

Parameters:
- WIDTH, 16: bits per sum/product element.
- MAX_N, 1024: element slots on each flattened result bus.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- done  input  1  accelerator done level; a rising edge triggers a frame.
- burst_len  input  10  element count; sampled on the trigger edge.
- sum_in_flat  input  WIDTH*MAX_N  accelerator sums; element i at [WIDTH*i +: WIDTH].
- product_in_flat  input  WIDTH*MAX_N  accelerator products; same packing.
- m_valid  output  1  beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  2*WIDTH  {product[i], sum[i]}; product in the upper half.
- m_index  output  10  element index i of the current beat.
- m_last  output  1  high on the final beat of the frame.
- busy  output  1  high from trigger until the last beat is accepted.
- frame_done  output  1  one-cycle pulse at frame end.
- overrun_err  output  1  sticky: a trigger arrived while busy.

Behaviour:
- Reset (async assert, sync release):
  - done_q, len_q, rd_idx, m_data, m_index and the checksum clear to 0.
  - m_valid, m_last, busy, frame_done and overrun_err clear to 0.
  - State is IDLE.
  - Reset mid-frame aborts immediately; no partial beat remains valid.
- Trigger: done_q registers done every cycle; trig = done & ~done_q.
  - A `done` held high out of reset produces a trigger on the first clock after release (done_q resets to 0).
- IDLE:
  - On trig with burst_len == 0: pulse frame_done next cycle, stay in IDLE, emit no beats.
  - On trig with burst_len != 0:
    - Latch len_q = burst_len.
    - Load beat 0: m_data from element 0, m_index = 0, m_last = (len_q == 1).
    - Set m_valid = 1 and busy = 1, enter STREAM.
  - m_valid therefore rises on the clock edge after the edge on which trig is sampled high.
- STREAM:
  - m_data, m_index and m_last hold stable while m_valid & ~m_ready.
  - On accept (m_valid & m_ready) of a non-last beat: load element rd_idx+1 on the same edge, m_valid stays 1 (full throughput, 1 beat/cycle).
  - On accept of the last beat:
    - m_valid = 0, busy = 0, m_last = 0.
    - frame_done pulses for one cycle on the following cycle.
    - Return to IDLE.
- Element select: combinational index into the flat buses by rd_idx, which is 10 bits.
  - len_q ≤ 1023 < MAX_N, so there is no wrap.
  - Result buses must stay stable for the frame; the accelerator holds them until its next start.
- Trigger while busy: ignored for sequencing, sets overrun_err (sticky until reset). The current frame completes unaffected.
- m_ready while m_valid = 0 has no effect.

Optional Feature:
- Macro RESULT_CHECKSUM_EN.
- Defined:
  - Adds output frame_csum [WIDTH-1:0].
  - The accumulator clears on the trigger.
  - Each accepted beat adds sum[i] + product[i], modulo 2^WIDTH.
  - frame_csum updates to the final value in the same cycle frame_done pulses and holds until the next frame's frame_done.
  - A zero-length frame reports 0.
- Undefined: no frame_csum port and no accumulator logic; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: burst_len = 4, sums = {1,2,3,4}, products = {0x10,0x20,0x30,0x40}, m_ready tied 1, raise done.
  - Response: beats m_data = 0x00100001, 0x00200002, 0x00300003, 0x00400004 on consecutive cycles; m_index 0..3; m_last only on index 3.
  - Then frame_done pulses once.
  - With RESULT_CHECKSUM_EN: frame_csum = 0x00AA.
- Back-pressure:
  - Stimulus: burst_len = 3, m_ready pattern 0,0,1,0,1,1.
  - Response: exactly 3 accepts; m_data and m_index stable during every stall cycle; busy low only after the third accept.
- Zero length: burst_len = 0, raise done -> no m_valid; one frame_done pulse; busy stays 0.
- Overrun: during a burst_len = 8 frame, drop and re-raise done at beat 3 -> overrun_err = 1 and stays set; all 8 beats are still delivered in order.
- Reset mid-frame: assert rst_n = 0 during beat 5 of 10 -> all outputs 0 asynchronously. After release with done low, then raise done, a fresh frame starts at m_index 0.
- Maximum length: burst_len = 1023 -> m_last on m_index 1022, and element 1022 is correctly selected.

Source files
------------

// File: rtl/hw_result_streamer.sv
// Serialises the accelerator's flattened sum/product buses into a valid/ready beat stream.
// Optional per-frame checksum output enabled by defining RESULT_CHECKSUM_EN.
module hw_result_streamer #(
  parameter int WIDTH = 16,
  parameter int MAX_N = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     done,
  input  logic [9:0]               burst_len,
  input  logic [WIDTH*MAX_N-1:0]   sum_in_flat,
  input  logic [WIDTH*MAX_N-1:0]   product_in_flat,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [2*WIDTH-1:0]       m_data,
  output logic [9:0]               m_index,
  output logic                     m_last,
  output logic                     busy,
  output logic                     frame_done,
`ifdef RESULT_CHECKSUM_EN
  output logic [WIDTH-1:0]         frame_csum,
`endif
  output logic                     overrun_err
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_next;
  logic             done_q;
  logic [9:0]       len_q;
  logic [9:0]       rd_idx;
  logic             trig;
  logic             accept;
  logic             load_first;
  logic             load_next;
  logic             last_accept;
  logic             zero_trig;
  logic [9:0]       sel_idx;
  logic [9:0]       last_idx;
  logic             next_last;
  logic [WIDTH-1:0] sel_sum;
  logic [WIDTH-1:0] sel_prod;

  assign trig   = done & ~done_q;
  assign accept = m_valid & m_ready;

  always_comb begin
    state_next  = state;
    load_first  = 1'b0;
    load_next   = 1'b0;
    last_accept = 1'b0;
    zero_trig   = 1'b0;
    case (state)
      IDLE: begin
        if (trig) begin
          if (burst_len == 10'd0) begin
            zero_trig = 1'b1;
          end else begin
            load_first = 1'b1;
            state_next = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          if (m_last) begin
            last_accept = 1'b1;
            state_next  = IDLE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The element loaded on an edge is the one after the current beat, or 0 at frame start.
  assign sel_idx   = load_first ? 10'd0 : rd_idx + 10'd1;
  assign last_idx  = load_first ? burst_len - 10'd1 : len_q - 10'd1;
  assign next_last = (sel_idx == last_idx);
  assign sel_sum   = sum_in_flat[WIDTH*sel_idx +: WIDTH];
  assign sel_prod  = product_in_flat[WIDTH*sel_idx +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      len_q       <= '0;
      rd_idx      <= '0;
      m_data      <= '0;
      m_index     <= '0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state      <= state_next;
      done_q     <= done;
      frame_done <= last_accept | zero_trig;
      if (trig && (state == STREAM)) overrun_err <= 1'b1;
      if (load_first) len_q <= burst_len;
      if (load_first || load_next) begin
        rd_idx  <= sel_idx;
        m_index <= sel_idx;
        m_data  <= {sel_prod, sel_sum};
        m_last  <= next_last;
        m_valid <= 1'b1;
        busy    <= 1'b1;
      end
      if (last_accept) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        busy    <= 1'b0;
      end
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0] csum_acc;
  logic [WIDTH-1:0] beat_add;

  assign beat_add = m_data[WIDTH-1:0] + m_data[2*WIDTH-1:WIDTH];

  // Published value only changes alongside frame_done; the running sum stays internal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_acc   <= '0;
      frame_csum <= '0;
    end else begin
      if (load_first || zero_trig) begin
        csum_acc <= '0;
      end else if (accept) begin
        csum_acc <= csum_acc + beat_add;
      end
      if (last_accept) frame_csum <= csum_acc + beat_add;
      else if (zero_trig) frame_csum <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_hw_result_streamer.sv
// Directed self-checking bench for hw_result_streamer; checksum checks active with RESULT_CHECKSUM_EN.
module tb_hw_result_streamer;
  localparam int WIDTH = 16;
  localparam int MAX_N = 1024;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   done;
  logic [9:0]             burst_len;
  logic [WIDTH*MAX_N-1:0] sum_in_flat;
  logic [WIDTH*MAX_N-1:0] product_in_flat;
  logic                   m_valid;
  logic                   m_ready;
  logic [2*WIDTH-1:0]     m_data;
  logic [9:0]             m_index;
  logic                   m_last;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun_err;
`ifdef RESULT_CHECKSUM_EN
  logic [WIDTH-1:0]       frame_csum;
`endif

  int passed = 0;
  int total  = 0;

  hw_result_streamer #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .done            (done),
    .burst_len       (burst_len),
    .sum_in_flat     (sum_in_flat),
    .product_in_flat (product_in_flat),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_index         (m_index),
    .m_last          (m_last),
    .busy            (busy),
    .frame_done      (frame_done),
`ifdef RESULT_CHECKSUM_EN
    .frame_csum      (frame_csum),
`endif
    .overrun_err     (overrun_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bus contents: sum[i] = i+1, product[i] = 16*(i+1), both truncated to 16 bits.
  function automatic logic [31:0] exp_data(input int i);
    logic [15:0] s;
    logic [15:0] p;
    s = 16'(i + 1);
    p = 16'((i + 1) * 16);
    return {p, s};
  endfunction

  logic [5:0] pat;
  int         exp_idx;

  initial begin
    rst_n     = 1'b0;
    done      = 1'b0;
    burst_len = '0;
    m_ready   = 1'b1;
    for (int i = 0; i < MAX_N; i++) begin
      sum_in_flat[WIDTH*i +: WIDTH]     = 16'(i + 1);
      product_in_flat[WIDTH*i +: WIDTH] = 16'((i + 1) * 16);
    end
    #23;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovr", overrun_err, 0);
    check("rst_data", m_data, 0);
    check("rst_index", m_index, 0);
    check("rst_last", m_last, 0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_valid", m_valid, 0);

    // Basic frame
    burst_len = 10'd4;
    done      = 1'b1;
    step();
    check("b0_valid", m_valid, 1);
    check("b0_busy", busy, 1);
    check("b0_data", m_data, 32'h0010_0001);
    check("b0_index", m_index, 0);
    check("b0_last", m_last, 0);
    step();
    check("b1_data", m_data, 32'h0020_0002);
    check("b1_index", m_index, 1);
    check("b1_last", m_last, 0);
    step();
    check("b2_data", m_data, 32'h0030_0003);
    check("b2_index", m_index, 2);
    check("b2_last", m_last, 0);
    step();
    check("b3_data", m_data, 32'h0040_0004);
    check("b3_index", m_index, 3);
    check("b3_last", m_last, 1);
    check("b3_fd", frame_done, 0);
    step();
    check("bend_valid", m_valid, 0);
    check("bend_busy", busy, 0);
    check("bend_fd", frame_done, 1);
`ifdef RESULT_CHECKSUM_EN
    check("bend_csum", frame_csum, 16'h00AA);
`endif
    step();
    check("bend_fd_clear", frame_done, 0);
    done = 1'b0;
    step();

    // Back-pressure: ready pattern 0,0,1,0,1,1 (LSB first)
    burst_len = 10'd3;
    m_ready   = 1'b0;
    done      = 1'b1;
    step();
    pat     = 6'b110100;
    exp_idx = 0;
    for (int k = 0; k < 6; k++) begin
      m_ready = pat[k];
      check("bp_valid", m_valid, 1);
      check("bp_busy", busy, 1);
      check("bp_index", m_index, exp_idx);
      check("bp_data", m_data, exp_data(exp_idx));
      check("bp_last", m_last, (exp_idx == 2));
      step();
      if (pat[k]) exp_idx++;
    end
    check("bp_accepts", exp_idx, 3);
    check("bp_end_valid", m_valid, 0);
    check("bp_end_busy", busy, 0);
    check("bp_end_fd", frame_done, 1);
    m_ready = 1'b1;
    done    = 1'b0;
    step();
    check("bp_fd_clear", frame_done, 0);

    // Zero length
    burst_len = 10'd0;
    done      = 1'b1;
    step();
    check("z_fd", frame_done, 1);
    check("z_valid", m_valid, 0);
    check("z_busy", busy, 0);
`ifdef RESULT_CHECKSUM_EN
    check("z_csum", frame_csum, 16'h0000);
`endif
    step();
    check("z_fd_clear", frame_done, 0);
    check("z_valid2", m_valid, 0);
    check("z_busy2", busy, 0);
    done = 1'b0;
    step();

    // Overrun: done drops and re-rises while beat 3 is presented
    burst_len = 10'd8;
    done      = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 2) done = 1'b0;
      if (i == 3) done = 1'b1;
      check("ov_valid", m_valid, 1);
      check("ov_index", m_index, i);
      check("ov_data", m_data, exp_data(i));
      check("ov_last", m_last, (i == 7));
      if (i == 4) check("ov_err_set", overrun_err, 1);
      step();
    end
    check("ov_end_valid", m_valid, 0);
    check("ov_end_fd", frame_done, 1);
    check("ov_err_held", overrun_err, 1);
`ifdef RESULT_CHECKSUM_EN
    check("ov_csum", frame_csum, 16'h0264);
`endif
    done = 1'b0;
    step();
    step();
    check("ov_err_sticky", overrun_err, 1);

    // Reset mid-frame at beat 5 of 10
    burst_len = 10'd10;
    done      = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check("rm_index5", m_index, 5);
    check("rm_valid5", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rm_valid", m_valid, 0);
    check("rm_data", m_data, 0);
    check("rm_index", m_index, 0);
    check("rm_last", m_last, 0);
    check("rm_busy", busy, 0);
    check("rm_ovr", overrun_err, 0);
    check("rm_fd", frame_done, 0);
    done = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("rm_idle", m_valid, 0);
    done = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      check("rm2_valid", m_valid, 1);
      check("rm2_index", m_index, i);
      check("rm2_data", m_data, exp_data(i));
      step();
    end
    check("rm2_fd", frame_done, 1);
    done = 1'b0;
    step();

    // Maximum length
    burst_len = 10'd1023;
    done      = 1'b1;
    step();
    for (int i = 0; i < 1023; i++) begin
      check("mx_valid", m_valid, 1);
      check("mx_index", m_index, i);
      check("mx_last", m_last, (i == 1022));
      if (i == 1022) check("mx_data_1022", m_data, 32'h3FF0_03FF);
      step();
    end
    check("mx_end_valid", m_valid, 0);
    check("mx_end_busy", busy, 0);
    check("mx_end_fd", frame_done, 1);
    done = 1'b0;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
